// File: rtl/ara_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ara_pkg
// Description : Shared slide-unit types and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ara_pkg;

    typedef enum logic {
        SLDU_DOWN = 1'b0,
        SLDU_UP   = 1'b1
    } sldu_dir_e;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sldu_byte_rot.sv
`default_nettype none
// ============================================================================
// Module      : sldu_byte_rot
// Description : Combinational byte rotator for one power-of-two slide component.
// Revision    : 1.0 - initial release
// ============================================================================
module sldu_byte_rot
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes = 4
) (
    input  logic [64*NrLanes-1:0]                 data_i,
    input  logic                                  dir_i,
    input  logic [idx_width(8*NrLanes)-1:0]       amount_i,
    output logic [64*NrLanes-1:0]                 data_o
);

    localparam int unsigned W           = 8 * NrLanes;
    localparam int unsigned StrideWidth = idx_width(W);

    // W is a power of two, so truncating the index sum gives the modulo wrap.
    for (genvar i = 0; i < W; i++) begin : g_byte
        localparam logic [StrideWidth-1:0] c_idx = StrideWidth'(i);
        logic [StrideWidth-1:0] w_src;

        assign w_src = (sldu_dir_e'(dir_i) == SLDU_UP) ? (c_idx - amount_i)
                                                       : (c_idx + amount_i);
        assign data_o[8*i +: 8] = data_i[8*w_src +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/sldu_p2_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : sldu_p2_shift_engine
// Description : Rotates one slide beat per p2 stride component until the
//               external generator runs empty, then presents it downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module sldu_p2_shift_engine
    import ara_pkg::*;
#(
    parameter  int unsigned NrLanes     = 4,
    localparam int unsigned StrideWidth = idx_width(8*NrLanes)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [64*NrLanes-1:0]    data_i,
    input  logic [StrideWidth-1:0]   stride_i,
    input  logic                     dir_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [StrideWidth-1:0]   gen_stride_o,
    output logic                     gen_valid_o,
    input  logic [StrideWidth-1:0]   gen_stride_p2_i,
    input  logic                     gen_valid_i,
    output logic                     gen_update_o,
    output logic [64*NrLanes-1:0]    data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [StrideWidth:0]     passes_o,
    output logic                     busy_o
);

    localparam int unsigned DW = 64 * NrLanes;
    localparam logic [StrideWidth:0] c_one_pass = (StrideWidth+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 r_state;
    logic [DW-1:0]          r_buf;
    logic                   r_dir;
    logic [StrideWidth:0]   r_passes;

    logic [DW-1:0]          w_rot_in;
    logic                   w_rot_dir;
    logic [DW-1:0]          w_rot_out;

    // In IDLE the first component is applied straight to the incoming beat.
    assign w_rot_in  = (r_state == IDLE) ? data_i : r_buf;
    assign w_rot_dir = (r_state == IDLE) ? dir_i  : r_dir;

    sldu_byte_rot #(
        .NrLanes (NrLanes)
    ) u_rot (
        .data_i   (w_rot_in),
        .dir_i    (w_rot_dir),
        .amount_i (gen_stride_p2_i),
        .data_o   (w_rot_out)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_buf    <= '0;
            r_dir    <= SLDU_DOWN;
            r_passes <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_dir <= dir_i;
                        if (gen_valid_i) begin
                            r_buf    <= w_rot_out;
                            r_passes <= c_one_pass;
                            r_state  <= SHIFT;
                        end else begin
                            r_buf    <= data_i;
                            r_passes <= '0;
                            r_state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (gen_valid_i) begin
                        r_buf    <= w_rot_out;
                        r_passes <= r_passes + c_one_pass;
                    end else begin
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o      = (r_state == IDLE);
    assign valid_o      = (r_state == DONE);
    assign busy_o       = (r_state != IDLE);
    assign data_o       = r_buf;
    assign passes_o     = r_passes;
    assign gen_stride_o = stride_i;
    assign gen_valid_o  = valid_i & ready_o;
    // The load already consumed the first component, so SHIFT only updates.
    assign gen_update_o = (r_state == SHIFT) & gen_valid_i;

endmodule
`default_nettype wire

// File: tb/tb_sldu_p2_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sldu_p2_shift_engine
// Description : Directed scoreboard bench with a behavioural p2 stride generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sldu_p2_shift_engine;

    localparam int unsigned NR_LANES = 4;
    localparam int unsigned W        = 8 * NR_LANES;
    localparam int unsigned DW       = 8 * W;
    localparam int unsigned SW       = 5;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [DW-1:0]   data_i = '0;
    logic [SW-1:0]   stride_i = '0;
    logic            dir_i = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [SW-1:0]   gen_stride_o;
    logic            gen_valid_o;
    logic [SW-1:0]   gen_stride_p2_i;
    logic            gen_valid_i;
    logic            gen_update_o;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [SW:0]     passes_o;
    logic            busy_o;

    sldu_p2_shift_engine #(
        .NrLanes (NR_LANES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .data_i          (data_i),
        .stride_i        (stride_i),
        .dir_i           (dir_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .gen_stride_o    (gen_stride_o),
        .gen_valid_o     (gen_valid_o),
        .gen_stride_p2_i (gen_stride_p2_i),
        .gen_valid_i     (gen_valid_i),
        .gen_update_o    (gen_update_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .passes_o        (passes_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural generator: lowest set bit of the load value or the remainder.
    logic [SW-1:0] r_rem;
    logic [SW-1:0] w_gen_src;
    assign w_gen_src       = gen_valid_o ? gen_stride_o : r_rem;
    assign gen_stride_p2_i = w_gen_src & (~w_gen_src + 1'b1);
    assign gen_valid_i     = |gen_stride_p2_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)             r_rem <= '0;
        else if (gen_valid_o)  r_rem <= gen_stride_o & ~gen_stride_p2_i;
        else if (gen_update_o) r_rem <= r_rem & ~gen_stride_p2_i;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [SW:0]   passes;
        int            lat;
        int            upd;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rot(input logic [DW-1:0] d, input int s, input logic up);
        logic [DW-1:0] r;
        int j;
        r = '0;
        for (int i = 0; i < W; i++) begin
            j = up ? ((i - s + W) % W) : ((i + s) % W);
            r[8*i +: 8] = d[8*j +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] seq_data();
        logic [DW-1:0] r;
        for (int i = 0; i < W; i++) r[8*i +: 8] = 8'(i);
        return r;
    endfunction

    task automatic wait_ready();
        for (int t = 0; t < 50 && !ready_o; t++) @(negedge clk_i);
        check("ready_wait", DW'(ready_o), DW'(1));
    endtask

    // Drive one beat, check it, then release it after 'hold' stalled cycles
    // during which the next beat (nd/ns/ndir) is presented and must be ignored.
    task automatic run_beat(input logic [DW-1:0] d, input int s, input logic up,
                            input int hold, input logic [DW-1:0] nd, input int ns,
                            input logic nup);
        exp_t e;
        exp_t got_e;
        int   k;
        int   cyc;
        int   upd;
        bit   got;
        @(negedge clk_i);
        wait_ready();
        data_i   = d;
        stride_i = SW'(s);
        dir_i    = up;
        valid_i  = 1'b1;
        #1;
        check("load_strobe", DW'(gen_valid_o), DW'(1));
        check("load_stride", DW'(gen_stride_o), DW'(s));
        k        = $countones(SW'(s));
        e.data   = ref_rot(d, s, up);
        e.passes = (SW+1)'(k);
        e.lat    = (k == 0) ? 1 : k + 1;
        e.upd    = (k == 0) ? 0 : k - 1;
        q_exp.push_back(e);
        upd = 0;
        cyc = 0;
        got = 1'b0;
        if (gen_update_o) upd++;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (valid_o) got = 1'b1;
            else if (gen_update_o) upd++;
        end
        check("valid_seen", DW'(got), DW'(1));
        got_e = q_exp.pop_front();
        check("latency", DW'(cyc), DW'(got_e.lat));
        check("data", data_o, got_e.data);
        check("passes", DW'(passes_o), DW'(got_e.passes));
        check("update_count", DW'(upd), DW'(got_e.upd));
        check("update_in_done", DW'(gen_update_o), DW'(0));
        if (hold > 0) begin
            data_i   = nd;
            stride_i = SW'(ns);
            dir_i    = nup;
            valid_i  = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                check("hold_data", data_o, got_e.data);
                check("hold_passes", DW'(passes_o), DW'(got_e.passes));
                check("hold_ready", DW'(ready_o), DW'(0));
                check("hold_no_load", DW'(gen_valid_o), DW'(0));
                check("hold_valid", DW'(valid_o), DW'(1));
            end
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        check("back_to_idle", DW'(ready_o), DW'(1));
    endtask

    initial begin
        logic [DW-1:0] seq;
        logic [DW-1:0] rnd;
        seq = seq_data();
        for (int i = 0; i < DW / 32; i++) rnd[32*i +: 32] = $urandom;

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_ready", DW'(ready_o), DW'(1));
        check("rst_valid", DW'(valid_o), DW'(0));
        check("rst_data", data_o, '0);
        check("rst_passes", DW'(passes_o), DW'(0));
        check("rst_gen_valid", DW'(gen_valid_o), DW'(0));
        check("rst_update", DW'(gen_update_o), DW'(0));
        check("rst_busy", DW'(busy_o), DW'(0));

        run_beat(seq, 0, 1'b0, 0, '0, 0, 1'b0);
        run_beat(seq, 5, 1'b0, 0, '0, 0, 1'b0);
        check("s5_byte0", DW'(data_o[7:0]), DW'(5));
        check("s5_byte31", DW'(data_o[255:248]), DW'(4));
        run_beat(seq, 31, 1'b1, 0, '0, 0, 1'b0);
        check("s31_byte0", DW'(data_o[7:0]), DW'(1));
        check("s31_byte31", DW'(data_o[255:248]), DW'(0));
        run_beat(seq, 16, 1'b1, 0, '0, 0, 1'b0);
        check("s16_byte0", DW'(data_o[7:0]), DW'(16));
        check("s16_byte16", DW'(data_o[135:128]), DW'(0));
        run_beat(rnd, 7, 1'b0, 0, '0, 0, 1'b0);
        run_beat(rnd, 10, 1'b1, 0, '0, 0, 1'b0);

        // Backpressure with a new beat waiting, then that beat right after.
        run_beat(seq, 5, 1'b0, 4, rnd, 13, 1'b1);
        run_beat(rnd, 13, 1'b1, 0, '0, 0, 1'b0);

        // Reset during SHIFT of a stride-31 beat.
        @(negedge clk_i);
        wait_ready();
        data_i   = seq;
        stride_i = SW'(31);
        dir_i    = 1'b1;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("mid_busy", DW'(busy_o), DW'(1));
        rst_i = 1'b1;
        #1;
        check("mrst_valid", DW'(valid_o), DW'(0));
        check("mrst_data", data_o, '0);
        check("mrst_passes", DW'(passes_o), DW'(0));
        check("mrst_ready", DW'(ready_o), DW'(1));
        check("mrst_busy", DW'(busy_o), DW'(0));
        check("mrst_update", DW'(gen_update_o), DW'(0));
        #1 rst_i = 1'b0;

        run_beat(seq, 3, 1'b0, 0, '0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
